// File: rtl/bus_datapath_p.sv
// bus_datapath_p: single-bus datapath with a general register file,
// special registers and a sequenced signed multiply/divide ALU.
// Ports: clk, reset (async, active-low); bus_sel selects the bus
// source; reg_we and the *_we strobes load registers from the bus;
// mdr_read picks the MDR source; alu_op/alu_start drive the ALU,
// which reports alu_busy, alu_done and div_zero; bus, z_out,
// pc_out, ir_out, mar_out, mdr_out and out_port expose state.
module bus_datapath_p #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 0,
  parameter int SELW    = $clog2(NREGS + 8)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SELW-1:0]      bus_sel,
  input  logic [NREGS-1:0]     reg_we,
  input  logic                 y_we,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic                 pc_we,
  input  logic                 ir_we,
  input  logic                 mar_we,
  input  logic                 out_we,
  input  logic                 mdr_we,
  input  logic                 mdr_read,
  input  logic [WIDTH-1:0]     mem_data_in,
  input  logic [WIDTH-1:0]     in_port_data,
  input  logic [WIDTH-1:0]     const_in,
  input  logic [3:0]           alu_op,
  input  logic                 alu_start,
  output logic                 alu_busy,
  output logic                 alu_done,
  output logic                 div_zero,
  output logic [WIDTH-1:0]     bus,
  output logic [2*WIDTH-1:0]   z_out,
  output logic [WIDTH-1:0]     pc_out,
  output logic [WIDTH-1:0]     ir_out,
  output logic [WIDTH-1:0]     mar_out,
  output logic [WIDTH-1:0]     mdr_out,
  output logic [WIDTH-1:0]     out_port
);

  localparam int RW  = $clog2(NREGS);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int W2  = 2 * WIDTH;

  localparam logic [SELW-1:0] S_HI  = SELW'(NREGS);
  localparam logic [SELW-1:0] S_LO  = SELW'(NREGS + 1);
  localparam logic [SELW-1:0] S_ZH  = SELW'(NREGS + 2);
  localparam logic [SELW-1:0] S_ZL  = SELW'(NREGS + 3);
  localparam logic [SELW-1:0] S_PC  = SELW'(NREGS + 4);
  localparam logic [SELW-1:0] S_MDR = SELW'(NREGS + 5);
  localparam logic [SELW-1:0] S_IN  = SELW'(NREGS + 6);
  localparam logic [SELW-1:0] S_K   = SELW'(NREGS + 7);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX
  } state_t;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] y, hi, lo, in_port;

  // ---------------- bus ----------------
  always_comb begin
    bus = '0;
    case (bus_sel)
      S_HI:    bus = hi;
      S_LO:    bus = lo;
      S_ZH:    bus = z_out[W2-1:WIDTH];
      S_ZL:    bus = z_out[WIDTH-1:0];
      S_PC:    bus = pc_out;
      S_MDR:   bus = mdr_out;
      S_IN:    bus = in_port;
      S_K:     bus = const_in;
      default: begin
        if (bus_sel < S_HI)
          bus = regs[bus_sel[RW-1:0]];
      end
    endcase
  end

  // ---------------- registers ----------------
  // R0 is never written when hard-wired, so it stays at its reset 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (reg_we[i] && !(i == 0 && R0_ZERO != 0))
          regs[i] <= bus;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y        <= '0;
      hi       <= '0;
      lo       <= '0;
      pc_out   <= '0;
      ir_out   <= '0;
      mar_out  <= '0;
      mdr_out  <= '0;
      out_port <= '0;
      in_port  <= '0;
    end else begin
      in_port <= in_port_data;
      if (y_we)   y        <= bus;
      if (hi_we)  hi       <= bus;
      if (lo_we)  lo       <= bus;
      if (pc_we)  pc_out   <= bus;
      if (ir_we)  ir_out   <= bus;
      if (mar_we) mar_out  <= bus;
      if (out_we) out_port <= bus;
      if (mdr_we) mdr_out  <= mdr_read ? mem_data_in : bus;
    end
  end

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0] a, b, res, abs_a, abs_b;
  logic [SHW-1:0]   sh;
  logic [W2-1:0]    aa, rot_r, rot_l;

  assign a     = y;
  assign b     = bus;
  assign sh    = b[SHW-1:0];
  assign aa    = {a, a};
  assign rot_r = aa >> sh;
  assign rot_l = aa << sh;
  assign abs_a = a[WIDTH-1] ? -a : a;
  assign abs_b = b[WIDTH-1] ? -b : b;

  always_comb begin
    res = b;
    case (alu_op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd4:    res = a >> sh;
      4'd5:    res = a << sh;
      4'd6:    res = rot_r[WIDTH-1:0];
      4'd7:    res = rot_l[W2-1:WIDTH];
      4'd8:    res = a & b;
      4'd9:    res = a | b;
      4'd10:   res = -b;
      4'd11:   res = ~b;
      4'd12:   res = b + WIDTH'(1);
      4'd13:   res = $signed(a) >>> sh;
      default: res = b;
    endcase
  end

  // ---------------- iterative mul/div ----------------
  // acc holds {partial, multiplier} for MUL and {rem, quotient}
  // for DIV; mag is the multiplicand or divisor magnitude.
  state_t           state;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] mag;
  logic [CW-1:0]    cnt;
  logic             sa, sb, is_div;

  logic [WIDTH:0]   madd, trial;
  logic [W2-1:0]    mul_next, div_next, prod, fix_z;
  logic [WIDTH-1:0] quo, rem;
  logic             op_mul, op_div;

  assign op_mul = (alu_op == 4'd2);
  assign op_div = (alu_op == 4'd3);

  assign madd = {1'b0, acc[W2-1:WIDTH]}
              + (acc[0] ? {1'b0, mag} : '0);
  assign mul_next = {madd, acc[WIDTH-1:1]};

  // Restoring step: a borrow in trial means the divisor did not fit.
  assign trial = {acc[W2-1:WIDTH], acc[WIDTH-1]}
               - {1'b0, mag};
  assign div_next = trial[WIDTH]
    ? {acc[W2-2:0], 1'b0}
    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod  = (sa ^ sb) ? -acc : acc;
  assign quo   = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem   = sa ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  assign fix_z = is_div ? {rem, quo} : prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      z_out    <= '0;
      acc      <= '0;
      mag      <= '0;
      cnt      <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      is_div   <= 1'b0;
      alu_busy <= 1'b0;
      alu_done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      alu_done <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (alu_start) begin
            if (op_mul || (op_div && b != '0)) begin
              sa       <= a[WIDTH-1];
              sb       <= b[WIDTH-1];
              is_div   <= op_div;
              cnt      <= CW'(WIDTH);
              alu_busy <= 1'b1;
              if (op_mul) begin
                acc   <= {{WIDTH{1'b0}}, abs_b};
                mag   <= abs_a;
                state <= S_MUL;
              end else begin
                acc   <= {{WIDTH{1'b0}}, abs_a};
                mag   <= abs_b;
                state <= S_DIV;
              end
            end else if (op_div) begin
              z_out    <= {a, {WIDTH{1'b1}}};
              alu_done <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              z_out    <= {{WIDTH{1'b0}}, res};
              alu_done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= S_FIX;
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= S_FIX;
        end
        S_FIX: begin
          z_out    <= fix_z;
          alu_busy <= 1'b0;
          alu_done <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_datapath_p.sv
// tb_bus_datapath_p: self-checking bench for bus_datapath_p with
// directed vectors, register moves and randomized ALU operations.
module tb_bus_datapath_p;

  localparam int NR = 16;

  localparam logic [4:0] S_HI  = 5'(NR);
  localparam logic [4:0] S_LO  = 5'(NR + 1);
  localparam logic [4:0] S_ZH  = 5'(NR + 2);
  localparam logic [4:0] S_ZL  = 5'(NR + 3);
  localparam logic [4:0] S_MDR = 5'(NR + 5);
  localparam logic [4:0] S_IN  = 5'(NR + 6);
  localparam logic [4:0] S_K   = 5'(NR + 7);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  bus_sel;
  logic [15:0] reg_we;
  logic        y_we, hi_we, lo_we, pc_we, ir_we, mar_we, out_we;
  logic        mdr_we, mdr_read;
  logic [31:0] mem_data_in, in_port_data, const_in;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        alu_busy, alu_done, div_zero;
  logic [31:0] bus, pc_out, ir_out, mar_out, mdr_out, out_port;
  logic [63:0] z_out;

  int ncmp = 0;
  int nerr = 0;

  bus_datapath_p #(
    .WIDTH(32), .NREGS(NR), .R0_ZERO(1)
  ) dut (
    .clk(clk), .reset(rst_n), .bus_sel(bus_sel),
    .reg_we(reg_we), .y_we(y_we), .hi_we(hi_we),
    .lo_we(lo_we), .pc_we(pc_we), .ir_we(ir_we),
    .mar_we(mar_we), .out_we(out_we), .mdr_we(mdr_we),
    .mdr_read(mdr_read), .mem_data_in(mem_data_in),
    .in_port_data(in_port_data), .const_in(const_in),
    .alu_op(alu_op), .alu_start(alu_start),
    .alu_busy(alu_busy), .alu_done(alu_done),
    .div_zero(div_zero), .bus(bus), .z_out(z_out),
    .pc_out(pc_out), .ir_out(ir_out), .mar_out(mar_out),
    .mdr_out(mdr_out), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
    logic        dz;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_sel = '0; reg_we = '0;
    y_we = 0; hi_we = 0; lo_we = 0; pc_we = 0; ir_we = 0;
    mar_we = 0; out_we = 0; mdr_we = 0; mdr_read = 0;
    alu_op = '0; alu_start = 0;
  endtask

  task automatic load_y(input logic [31:0] v);
    bus_sel = S_K; const_in = v; y_we = 1;
    tick();
    y_we = 0;
  endtask

  // Reference: plain signed arithmetic, returns {div_zero, Z}.
  function automatic logic [64:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  s;
    longint      sa, sb, q, m;
    s  = b[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = b;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: begin
        m = sa * sb;
        return {1'b0, m};
      end
      4'd3: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        m = sa % sb;
        return {1'b0, m[31:0], q[31:0]};
      end
      4'd4: r = a >> s;
      4'd5: r = a << s;
      4'd6: r = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      4'd7: r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4'd8: r = a & b;
      4'd9: r = a | b;
      4'd10: r = -b;
      4'd11: r = ~b;
      4'd12: r = b + 1;
      4'd13: r = $signed(a) >>> s;
      default: r = b;
    endcase
    return {1'b0, 32'h0, r};
  endfunction

  // Runs one op; a second start is pulsed mid-operation and the
  // bus source is scrambled so latching and start-ignore are exercised.
  task automatic run_alu(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [63:0] z, output logic dz,
                         output int lat, output int nbusy);
    load_y(a);
    bus_sel = S_K; const_in = b; alu_op = op; alu_start = 1;
    tick();
    alu_start = 0; alu_op = 4'd0; const_in = $urandom;
    lat = 1; nbusy = 0;
    while (!alu_done && lat < 60) begin
      if (alu_busy) nbusy++;
      alu_start = (lat == 5);
      tick();
      lat++;
    end
    alu_start = 0;
    z = z_out; dz = div_zero;
  endtask

  task automatic alu_check(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] ez, input logic edz);
    logic [63:0] z;
    logic        dz;
    int          lat, nb, elat;
    elat = (op == 4'd2 || (op == 4'd3 && b != 0)) ? 34 : 1;
    run_alu(op, a, b, z, dz, lat, nb);
    chk({tag, "_z"}, z, ez);
    chk({tag, "_dz"}, 64'(dz), 64'(edz));
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_busy"}, 64'(nb), 64'((elat == 34) ? 33 : 0));
  endtask

  initial begin
    logic [64:0] m;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    int          seen;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'd1, 64'h0, 1'b0};
    vecs[1]  = '{4'd6,  32'h1, 32'h1, 64'h8000_0000, 1'b0};
    vecs[2]  = '{4'd2,  32'hFFFF_FFF9, 32'd3,
                 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[3]  = '{4'd3,  32'hFFFF_FFF9, 32'd2,
                 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[4]  = '{4'd3,  32'd5, 32'd0,
                 64'h0000_0005_FFFF_FFFF, 1'b1};
    vecs[5]  = '{4'd3,  32'h8000_0000, 32'hFFFF_FFFF,
                 64'h0000_0000_8000_0000, 1'b0};
    vecs[6]  = '{4'd1,  32'd3, 32'd5, 64'hFFFF_FFFE, 1'b0};
    vecs[7]  = '{4'd13, 32'h8000_0000, 32'd4, 64'hF800_0000, 1'b0};
    vecs[8]  = '{4'd5,  32'h1, 32'h24, 64'h10, 1'b0};
    vecs[9]  = '{4'd10, 32'h0, 32'h1, 64'hFFFF_FFFF, 1'b0};
    vecs[10] = '{4'd12, 32'h0, 32'hFFFF_FFFF, 64'h0, 1'b0};
    vecs[11] = '{4'd15, 32'h0, 32'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0};
    vecs[12] = '{4'd7,  32'h8000_0001, 32'd1, 64'h3, 1'b0};
    vecs[13] = '{4'd2,  32'h1_0000, 32'h1_0000,
                 64'h1_0000_0000, 1'b0};
    vecs[14] = '{4'd3,  32'd7, 32'hFFFF_FFFE,
                 64'h0000_0001_FFFF_FFFD, 1'b0};

    idle();
    const_in = '0; mem_data_in = '0; in_port_data = '0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    bus_sel = 5'd3;
    #1;
    chk("rst_z", z_out, 64'h0);
    chk("rst_busy", 64'(alu_busy), 64'h0);
    chk("rst_done", 64'(alu_done), 64'h0);
    chk("rst_pc", 64'(pc_out), 64'h0);
    chk("rst_r3", 64'(bus), 64'h0);
    rst_n = 1;
    tick();

    bus_sel = S_K; const_in = 32'hAB;
    reg_we = 16'h0028;
    tick();
    idle();
    bus_sel = 5'd3; #1;
    chk("r3", 64'(bus), 64'hAB);
    bus_sel = 5'd5; #1;
    chk("r5", 64'(bus), 64'hAB);

    bus_sel = S_K; const_in = 32'h55; reg_we = 16'h0001;
    tick();
    idle();
    #1;
    chk("r0_zero", 64'(bus), 64'h0);

    bus_sel = 5'd3; pc_we = 1; mar_we = 1; ir_we = 1;
    tick();
    idle();
    chk("pc", 64'(pc_out), 64'hAB);
    chk("mar", 64'(mar_out), 64'hAB);
    chk("ir", 64'(ir_out), 64'hAB);

    mdr_read = 1; mem_data_in = 32'h1234_5678; mdr_we = 1;
    tick();
    idle();
    chk("mdr", 64'(mdr_out), 64'h1234_5678);
    bus_sel = S_MDR; out_we = 1;
    tick();
    idle();
    chk("outport", 64'(out_port), 64'h1234_5678);

    in_port_data = 32'hCAFE_F00D;
    tick();
    bus_sel = S_IN; #1;
    chk("inport", 64'(bus), 64'hCAFE_F00D);
    bus_sel = 5'd31; #1;
    chk("bad_sel", 64'(bus), 64'h0);

    for (int i = 0; i < 15; i++) begin
      alu_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a,
                vecs[i].b, vecs[i].z, vecs[i].dz);
      idle();
    end

    alu_check("mul_mv", 4'd2, 32'hFFFF_FFF9, 32'd3,
              64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    idle();
    bus_sel = S_ZH; hi_we = 1;
    tick();
    bus_sel = S_ZL; hi_we = 0; lo_we = 1;
    tick();
    idle();
    bus_sel = S_HI; #1;
    chk("hi", 64'(bus), 64'hFFFF_FFFF);
    bus_sel = S_LO; #1;
    chk("lo", 64'(bus), 64'hFFFF_FFEB);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if (i % 8 == 0) op = 4'd3;
      if (i % 8 == 1) op = 4'd2;
      m = model(op, ra, rb);
      alu_check($sformatf("rnd%0d_op%0d", i, op), op, ra, rb,
                m[63:0], m[64]);
      idle();
    end

    load_y(32'hFFFF_FFF9);
    bus_sel = S_K; const_in = 32'd3; alu_op = 4'd2; alu_start = 1;
    tick();
    idle();
    repeat (10) tick();
    rst_n = 0;
    #1;
    chk("abort_busy", 64'(alu_busy), 64'h0);
    chk("abort_z", z_out, 64'h0);
    #2;
    rst_n = 1;
    seen = 0;
    repeat (40) begin
      tick();
      if (alu_done) seen++;
    end
    chk("abort_nodone", 64'(seen), 64'h0);
    chk("abort_z2", z_out, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
